memory_sequencer: RTL and testbench
===================================

// Module: memory_sequencer
// PURPOSE
//  Owns the single shared memory port. Arbitrates it between instruction fetch (stage 0) and the
//  load/store stage, applies a fixed wait-state count per access and drives block_fetch into
//  stage 0, so a NOP enters the pipe whenever mem_data does not hold a valid instruction.
//  Data accesses have priority; a run limit guarantees fetch forward progress.
// PARAMETERS
//  WAIT_STATES   0  extra cycles per memory access (0..15); access length = WAIT_STATES+1 cycles
//  MAX_DATA_RUN  4  max back-to-back data accesses before one fetch is forced (1..15)
// PORTS
//  clock         in   1   system clock; all state changes on rising edge
//  reset         in   1   synchronous, active-high reset
//  pc            in   30  word address of next instruction (from program counter)
//  data_req      in   1   load/store stage requests the port; held high until data_ack
//  data_write    in   1   1 = store, 0 = load; sampled with data_req
//  data_address  in   30  word address of load/store; stable while data_req high
//  data_ack      out  1   one-cycle pulse: data access completes this cycle
//  block_fetch   out  1   to stage 0: 1 = mem_data not a valid instruction, insert NOP
//  mem_address   out  30  address driven to memory
//  mem_write     out  1   write strobe to memory
// BEHAVIOUR
//  State regs: state {HOLD, FETCH, DATA}; wait_count 4b; data_run 4b. Outputs decoded from them.
//  Reset (sync): state=HOLD, wait_count=0, data_run=0. Outputs during reset and in HOLD:
//   block_fetch=1, data_ack=0, mem_write=0, mem_address=pc.
//  HOLD: one cycle; always -> FETCH next edge (gives memory one cycle to present word at pc).
//  FETCH: mem_address=pc, mem_write=0. block_fetch=1 while wait_count<WAIT_STATES, 0 on final
//   cycle (wait_count==WAIT_STATES); stage 0 captures mem_data and raises inc_pc on that edge.
//   On final cycle: wait_count<=0, data_run<=0; data_req=1 -> DATA, else stay FETCH.
//  DATA: mem_address=data_address, mem_write=data_write on every cycle of the access;
//   block_fetch=1 throughout. data_ack=1 on final cycle only. On final cycle: wait_count<=0,
//   data_run<=data_run+1 (saturating); next = DATA if data_req still high and
//   data_run+1<MAX_DATA_RUN, else FETCH (forced fetch after run limit).
//  Non-final cycles: wait_count<=wait_count+1, state held.
//  data_req sampled only on FETCH final cycle and DATA final cycle; a request raised mid-fetch
//   waits for that fetch to finish (fetch is never aborted). Data latency from data_req rise
//   at a FETCH final cycle: data_ack after WAIT_STATES+1 further cycles.
//  data_req dropped mid-DATA: access still completes and acks (protocol violation, no hang).
//  WAIT_STATES=0: every access 1 cycle; alternating fetch/data gives block_fetch 0,1,0,1...
//  Reset mid-access: access abandoned, no data_ack; HOLD then FETCH at current pc.
//  pc changes mid-FETCH (branch): mem_address follows pc combinationally; wait_count not
//   restarted, so pc must be stable for the whole access (pipeline only branches after ack).
//  No X on outputs after reset; mem_write never 1 outside DATA.
// TESTING
//  1 Reset 3 cycles, WAIT_STATES=0, data_req=0 -> block_fetch 1 (reset),1 (HOLD), then 0 every
//    cycle; mem_address tracks pc=0x10,0x11,...
//  2 WAIT_STATES=2, no data -> block_fetch pattern 1,1,0 repeating; mem_write always 0.
//  3 WAIT_STATES=0, single load at 0x100 raised during FETCH -> next cycle mem_address=0x100,
//    data_ack=1, block_fetch=1; following cycle back to FETCH with mem_address=pc.
//  4 MAX_DATA_RUN=4, data_req held high, store to 0x200 -> 4 acks with mem_write=1, then one
//    fetch cycle (block_fetch=0, mem_write=0), then 4 more acks.
//  5 WAIT_STATES=3, reset asserted on 2nd cycle of DATA -> no data_ack, mem_write=0 next cycle,
//    HOLD then FETCH at pc; data_req still high -> data access restarts after that fetch.
//  6 WAIT_STATES=1, data_req dropped mid-DATA -> access completes, data_ack pulses once, FETCH.

Source files
------------

// File: rtl/memory_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : memory_sequencer
// Description : Arbitrates the single memory port between instruction fetch
//               and load/store, with fixed wait states and a data-run limit.
// Revision    : 1.0
// ============================================================================
module memory_sequencer #(
   parameter int WAIT_STATES  = 0,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [29:0] pc_i,
   input  logic        data_req_i,
   input  logic        data_write_i,
   input  logic [29:0] data_address_i,
   output logic        data_ack_o,
   output logic        block_fetch_o,
   output logic [29:0] mem_address_o,
   output logic        mem_write_o
);

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2
   } state_t;

   localparam logic [3:0] c_WAIT    = 4'(WAIT_STATES);
   localparam logic [4:0] c_MAX_RUN = 5'(MAX_DATA_RUN);

   state_t     state_q, state_d;
   logic [3:0] wait_count_q, wait_count_d;
   logic [3:0] data_run_q, data_run_d;
   logic       w_final;
   logic [4:0] w_run_inc;

   assign w_final   = (wait_count_q == c_WAIT);
   assign w_run_inc = {1'b0, data_run_q} + 5'd1;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= S_HOLD;
         wait_count_q <= 4'd0;
         data_run_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         wait_count_q <= wait_count_d;
         data_run_q   <= data_run_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_count_d  = wait_count_q;
      data_run_d    = data_run_q;
      data_ack_o    = 1'b0;
      block_fetch_o = 1'b1;
      mem_write_o   = 1'b0;
      mem_address_o = pc_i;

      case (state_q)
         S_HOLD: begin
            state_d      = S_FETCH;
            wait_count_d = 4'd0;
         end
         S_FETCH: begin
            if (w_final) begin
               block_fetch_o = 1'b0;
               wait_count_d  = 4'd0;
               data_run_d    = 4'd0;
               state_d       = data_req_i ? S_DATA : S_FETCH;
            end else begin
               wait_count_d = wait_count_q + 4'd1;
            end
         end
         S_DATA: begin
            mem_address_o = data_address_i;
            mem_write_o   = data_write_i;
            if (w_final) begin
               data_ack_o   = 1'b1;
               wait_count_d = 4'd0;
               data_run_d   = w_run_inc[4] ? 4'hF : w_run_inc[3:0];
               // Once the run limit is reached a fetch is forced even if data is still pending.
               state_d      = (data_req_i && (w_run_inc < c_MAX_RUN)) ? S_DATA : S_FETCH;
            end else begin
               wait_count_d = wait_count_q + 4'd1;
            end
         end
         default: begin
            state_d      = S_HOLD;
            wait_count_d = 4'd0;
            data_run_d   = 4'd0;
         end
      endcase

      // While reset is asserted the port looks idle, so an interrupted access never acks.
      if (reset_i) begin
         data_ack_o    = 1'b0;
         block_fetch_o = 1'b1;
         mem_write_o   = 1'b0;
         mem_address_o = pc_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_sequencer
// Description : Four sequencer instances with differing wait states and run
//               limits, directed opening followed by random traffic.
// Revision    : 1.0
// ============================================================================
module tb_memory_sequencer;

   localparam int NI    = 4;
   localparam int N_CYC = 3000;
   // Nibble i holds the parameter for instance i.
   localparam logic [15:0] WS_P  = 16'h3210;
   localparam logic [15:0] MDR_P = 16'h2134;
   localparam int K_HOLD  = 0;
   localparam int K_FETCH = 1;
   localparam int K_DATA  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst    [NI];
   logic [29:0] pc     [NI];
   logic        want   [NI];
   logic        single [NI];
   logic        dwr    [NI];
   logic [29:0] dadr   [NI];
   logic        req    [NI];
   logic        ack    [NI];
   logic        bf     [NI];
   logic        mw     [NI];
   logic [29:0] madr   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      // A single-access requester withdraws in the ack cycle so no second access starts.
      assign req[g] = want[g] & ~(single[g] & ack[g]);

      memory_sequencer #(
         .WAIT_STATES  (int'(WS_P[4*g +: 4])),
         .MAX_DATA_RUN (int'(MDR_P[4*g +: 4]))
      ) u_dut (
         .clock_i        (clk),
         .reset_i        (rst[g]),
         .pc_i           (pc[g]),
         .data_req_i     (req[g]),
         .data_write_i   (dwr[g]),
         .data_address_i (dadr[g]),
         .data_ack_o     (ack[g]),
         .block_fetch_o  (bf[g]),
         .mem_address_o  (madr[g]),
         .mem_write_o    (mw[g])
      );
   end

   function automatic int ws_of(int i);
      logic [15:0] p;
      p = WS_P;
      return int'(p[4*i +: 4]);
   endfunction

   function automatic int mdr_of(int i);
      logic [15:0] p;
      p = MDR_P;
      return int'(p[4*i +: 4]);
   endfunction

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int m_kind [NI] = '{0, 0, 0, 0};
   int m_left [NI] = '{0, 0, 0, 0};
   int m_run  [NI] = '{0, 0, 0, 0};

   task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, got, exp);
      end
   endtask

   // Compare process: model outputs, pinned literals, then advance the model.
   initial begin
      logic [31:0] e_bf, e_ack, e_mw, e_adr;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (rst[i] || m_kind[i] == K_HOLD) begin
               e_bf = 1; e_ack = 0; e_mw = 0; e_adr = 32'(pc[i]);
            end else if (m_kind[i] == K_FETCH) begin
               e_bf = (m_left[i] != 0) ? 1 : 0; e_ack = 0; e_mw = 0; e_adr = 32'(pc[i]);
            end else begin
               e_bf = 1; e_ack = (m_left[i] == 0) ? 1 : 0; e_mw = 32'(dwr[i]); e_adr = 32'(dadr[i]);
            end
            chk("block_fetch", i, 32'(bf[i]), e_bf);
            chk("data_ack", i, 32'(ack[i]), e_ack);
            chk("mem_write", i, 32'(mw[i]), e_mw);
            chk("mem_address", i, 32'(madr[i]), e_adr);
         end

         case (cyc)
            3:  chk("hold_bf", 0, 32'(bf[0]), 1);
            4:  begin
                   chk("fetch_bf", 0, 32'(bf[0]), 0);
                   chk("fetch_adr", 0, 32'(madr[0]), 32'h10);
                   chk("ws2_bf", 2, 32'(bf[2]), 1);
                end
            5:  begin
                   chk("fetch_adr", 0, 32'(madr[0]), 32'h11);
                   chk("ws2_bf", 2, 32'(bf[2]), 1);
                end
            6:  begin
                   chk("ws2_bf", 2, 32'(bf[2]), 0);
                   chk("ws2_adr", 2, 32'(madr[2]), 32'h10);
                end
            7:  chk("ws2_bf", 2, 32'(bf[2]), 1);
            9:  begin
                   chk("run_ack", 0, 32'(ack[0]), 1);
                   chk("run_mw", 0, 32'(mw[0]), 1);
                   chk("run_adr", 0, 32'(madr[0]), 32'h200);
                end
            10: begin
                   chk("ws1_adr", 1, 32'(madr[1]), 32'h300);
                   chk("ws1_ack", 1, 32'(ack[1]), 0);
                end
            11: chk("ws1_ack", 1, 32'(ack[1]), 1);
            12: begin
                   chk("run_ack", 0, 32'(ack[0]), 1);
                   chk("ws1_bf", 1, 32'(bf[1]), 1);
                   chk("ws1_adr", 1, 32'(madr[1]), 32'h13);
                   chk("ws3_mw", 3, 32'(mw[3]), 1);
                   chk("ws3_adr", 3, 32'(madr[3]), 32'h3FF0);
                end
            13: begin
                   chk("forced_bf", 0, 32'(bf[0]), 0);
                   chk("forced_mw", 0, 32'(mw[0]), 0);
                   chk("forced_adr", 0, 32'(madr[0]), 32'h15);
                   chk("rst_ack", 3, 32'(ack[3]), 0);
                   chk("rst_mw", 3, 32'(mw[3]), 0);
                   chk("ws1_bf", 1, 32'(bf[1]), 0);
                end
            14: begin
                   chk("hold_bf", 3, 32'(bf[3]), 1);
                   chk("hold_mw", 3, 32'(mw[3]), 0);
                   chk("hold_adr", 3, 32'(madr[3]), 32'h12);
                   chk("run2_ack", 0, 32'(ack[0]), 1);
                end
            17: chk("run2_ack", 0, 32'(ack[0]), 1);
            18: chk("after_run_bf", 0, 32'(bf[0]), 0);
            19: chk("restart_mw", 3, 32'(mw[3]), 1);
            21: begin
                   chk("load_adr", 0, 32'(madr[0]), 32'h100);
                   chk("load_ack", 0, 32'(ack[0]), 1);
                   chk("load_bf", 0, 32'(bf[0]), 1);
                   chk("ws3_ack", 3, 32'(ack[3]), 0);
                end
            22: begin
                   chk("load_ret_adr", 0, 32'(madr[0]), 32'h19);
                   chk("load_ret_bf", 0, 32'(bf[0]), 0);
                   chk("ws3_ack", 3, 32'(ack[3]), 1);
                end
            default: ;
         endcase

         // m_left counts the cycles of the current access still to come after this one.
         for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
               m_kind[i] = K_HOLD;
               m_run[i]  = 0;
            end else if (m_kind[i] == K_HOLD) begin
               m_kind[i] = K_FETCH;
               m_left[i] = ws_of(i);
            end else if (m_left[i] > 0) begin
               m_left[i] = m_left[i] - 1;
            end else if (m_kind[i] == K_FETCH) begin
               m_run[i]  = 0;
               m_kind[i] = req[i] ? K_DATA : K_FETCH;
               m_left[i] = ws_of(i);
            end else begin
               m_run[i]  = m_run[i] + 1;
               m_kind[i] = (req[i] && m_run[i] < mdr_of(i)) ? K_DATA : K_FETCH;
               m_left[i] = ws_of(i);
            end
         end
         cyc++;
      end
   end

   logic ack_prev [NI];
   logic bf_prev  [NI];
   int   rst_hold [NI] = '{0, 0, 0, 0};

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1; pc[i] = 30'h10; want[i] = 1'b0; single[i] = 1'b0;
         dwr[i] = 1'b0; dadr[i] = '0;
      end
      for (int k = 1; k <= N_CYC; k++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            ack_prev[i] = ack[i];
            bf_prev[i]  = bf[i];
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (!bf_prev[i]) pc[i] = pc[i] + 30'd1;
            if (ack_prev[i] && single[i]) want[i] = 1'b0;
            if (k < 30) begin
               rst[i] = (k < 3) || (i == 3 && k == 13);
            end else begin
               if (rst_hold[i] > 0) begin
                  rst[i] = 1'b1;
                  rst_hold[i] = rst_hold[i] - 1;
               end else if ($urandom_range(199) == 0) begin
                  rst[i] = 1'b1;
                  rst_hold[i] = int'($urandom_range(2));
               end else begin
                  rst[i] = 1'b0;
               end
               if (ack_prev[i] && !single[i] && $urandom_range(1) == 0) want[i] = 1'b0;
               if (ack_prev[i] && $urandom_range(3) == 0) pc[i] = 30'($urandom);
               if (!want[i]) begin
                  if ($urandom_range(2) == 0) begin
                     want[i]   = 1'b1;
                     single[i] = 1'($urandom_range(1));
                     dwr[i]    = 1'($urandom_range(1));
                     dadr[i]   = 30'($urandom);
                  end
               end else if ($urandom_range(49) == 0) begin
                  want[i] = 1'b0;
               end
            end
         end
         if (k == 8) begin
            want[0] = 1'b1; single[0] = 1'b0; dwr[0] = 1'b1; dadr[0] = 30'h200;
            want[1] = 1'b1; single[1] = 1'b0; dwr[1] = 1'b0; dadr[1] = 30'h300;
            want[3] = 1'b1; single[3] = 1'b1; dwr[3] = 1'b1; dadr[3] = 30'h3FF0;
         end
         if (k == 10) want[1] = 1'b0;
         if (k == 18) want[0] = 1'b0;
         if (k == 20) begin
            want[0] = 1'b1; single[0] = 1'b1; dwr[0] = 1'b0; dadr[0] = 30'h100;
         end
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
